// File: rtl/gray_count_decoder_if.sv
// Gray-count link bundle between a gray-count source (master) and the
// decoder (slave).
interface gray_count_decoder_if #(
    parameter int N = 4
);
    logic [N-1:0] gray_in;
    logic         clr_err;
    logic [N-1:0] bin_out;
    logic         bin_valid;
    logic         dir_up;
    logic         wrap;
    logic         step_err;
    logic [7:0]   err_cnt;

    modport master (
        output gray_in, clr_err,
        input  bin_out, bin_valid, dir_up, wrap, step_err, err_cnt
    );

    modport slave (
        input  gray_in, clr_err,
        output bin_out, bin_valid, dir_up, wrap, step_err, err_cnt
    );
endinterface

// File: rtl/gray_count_decoder.sv
// Consumer side of a gray-count link: samples, decodes to binary, flags multi-bit
// steps, direction and wraps. Define GRAY_DEC_SYNC_EN to add a 2-flop input synchronizer.
module gray_count_decoder #(
    parameter int N          = 4,
    parameter int STABLE_CYC = 2
) (
    input  logic                clk,
    input  logic                reset_al_in,
    gray_count_decoder_if.slave bus
);
    localparam int SW = (STABLE_CYC < 1) ? 1 : $clog2(STABLE_CYC + 1);

    typedef enum logic [1:0] {INIT, TRACK, ERR} state_t;

    function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [N-1:0] samp;

`ifdef GRAY_DEC_SYNC_EN
    // INIT waits until the synchronizer has carried the first post-reset sample through
    localparam int INIT_CYC = 3;
    logic [N-1:0] s1_q, s2_q;

    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= bus.gray_in;
            s2_q <= s1_q;
        end
    end

    assign samp = s2_q;
`else
    localparam int INIT_CYC = 1;
    assign samp = bus.gray_in;
`endif

    state_t       state_q, state_d;
    logic [1:0]   init_q, init_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [N-1:0] g_q, g_d;
    logic [N-1:0] g_prev_q, g_prev_d;
    logic [N-1:0] bin_q, bin_d;
    logic         valid_q, valid_d;
    logic         dir_q, dir_d;
    logic         wrap_q, wrap_d;
    logic         serr_q, serr_d;
    logic [7:0]   ecnt_q, ecnt_d;

    logic [N-1:0] diff;
    logic         changed;
    logic         multi;
    logic [N-1:0] dec_g;
    logic         up;

    // diff & (diff-1) is nonzero exactly when more than one bit differs
    assign diff    = g_q ^ g_prev_q;
    assign changed = |diff;
    assign multi   = |(diff & (diff - N'(1)));
    assign dec_g   = gray2bin(g_q);
    assign up      = ((dec_g - bin_q) == N'(1));

    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            state_q  <= INIT;
            init_q   <= '0;
            stab_q   <= '0;
            g_q      <= '0;
            g_prev_q <= '0;
            bin_q    <= '0;
            valid_q  <= 1'b0;
            dir_q    <= 1'b0;
            wrap_q   <= 1'b0;
            serr_q   <= 1'b0;
            ecnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            init_q   <= init_d;
            stab_q   <= stab_d;
            g_q      <= g_d;
            g_prev_q <= g_prev_d;
            bin_q    <= bin_d;
            valid_q  <= valid_d;
            dir_q    <= dir_d;
            wrap_q   <= wrap_d;
            serr_q   <= serr_d;
            ecnt_q   <= ecnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        init_d   = init_q;
        stab_d   = stab_q;
        g_d      = samp;
        g_prev_d = g_q;
        bin_d    = bin_q;
        valid_d  = 1'b0;
        dir_d    = dir_q;
        wrap_d   = 1'b0;
        serr_d   = 1'b0;

        case (state_q)
            INIT: begin
                // Seed both sample registers so the first TRACK cycle sees no change
                if (init_q == 2'(INIT_CYC - 1)) begin
                    bin_d    = gray2bin(samp);
                    g_prev_d = samp;
                    init_d   = '0;
                    state_d  = TRACK;
                end else begin
                    init_d = init_q + 2'd1;
                end
            end
            TRACK: begin
                if (multi) begin
                    serr_d  = 1'b1;
                    stab_d  = '0;
                    state_d = ERR;
                end else if (changed) begin
                    bin_d   = dec_g;
                    valid_d = 1'b1;
                    dir_d   = up;
                    wrap_d  = up ? (bin_q == {N{1'b1}}) : (bin_q == '0);
                end
            end
            ERR: begin
                if (changed) begin
                    stab_d = '0;
                    serr_d = multi;
                end else if (stab_q == SW'(STABLE_CYC - 1)) begin
                    bin_d   = dec_g;
                    valid_d = 1'b1;
                    stab_d  = '0;
                    state_d = TRACK;
                end else begin
                    stab_d = stab_q + SW'(1);
                end
            end
            default: state_d = INIT;
        endcase

        ecnt_d = ecnt_q;
        if (bus.clr_err)
            ecnt_d = '0;
        else if (serr_d && ecnt_q != 8'hFF)
            ecnt_d = ecnt_q + 8'd1;
    end

    assign bus.bin_out   = bin_q;
    assign bus.bin_valid = valid_q;
    assign bus.dir_up    = dir_q;
    assign bus.wrap      = wrap_q;
    assign bus.step_err  = serr_q;
    assign bus.err_cnt   = ecnt_q;
endmodule

// File: tb/tb_gray_count_decoder.sv
// Directed bench for gray_count_decoder: count-up sweep, wraps, step errors,
// err_cnt saturation/clear and mid-error reset.
module tb_gray_count_decoder;
    localparam int N    = 4;
    localparam int STAB = 2;
`ifdef GRAY_DEC_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int D = LAT + 1;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   vcnt    = 0;
    logic [3:0] gseq [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    gray_count_decoder_if #(.N(N)) bus();

    gray_count_decoder #(.N(N), .STABLE_CYC(STAB)) dut (
        .clk        (clk),
        .reset_al_in(rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        vcnt += int'(bus.bin_valid);
    endtask

    task automatic apply(input logic [3:0] g);
        bus.gray_in = g;
        repeat (D) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        bus.gray_in = '0;
        bus.clr_err = 1'b0;
        repeat (3) tick();
        chk("rst_bin",   32'(bus.bin_out),   32'h0);
        chk("rst_valid", 32'(bus.bin_valid), 32'h0);
        chk("rst_dir",   32'(bus.dir_up),    32'h0);
        chk("rst_wrap",  32'(bus.wrap),      32'h0);
        chk("rst_serr",  32'(bus.step_err),  32'h0);
        chk("rst_ecnt",  32'(bus.err_cnt),   32'h0);

        rst_n = 1'b1;
        repeat (LAT) tick();
        chk("init_bin",   32'(bus.bin_out),   32'h0);
        chk("init_valid", 32'(bus.bin_valid), 32'h0);

        // 1: full up-count sweep
        vcnt = 0;
        for (int i = 1; i < 16; i++) begin
            apply(gseq[i]);
            chk($sformatf("t1_bin%0d", i),  32'(bus.bin_out),   32'(i));
            chk($sformatf("t1_vld%0d", i),  32'(bus.bin_valid), 32'h1);
            chk($sformatf("t1_dir%0d", i),  32'(bus.dir_up),    32'h1);
            chk($sformatf("t1_serr%0d", i), 32'(bus.step_err),  32'h0);
            chk($sformatf("t1_wrap%0d", i), 32'(bus.wrap),      32'h0);
        end
        chk("t1_vcnt", 32'(vcnt), 32'd15);

        // 2: wrap up then wrap down
        apply(4'h0);
        chk("t2_up_bin",  32'(bus.bin_out), 32'h0);
        chk("t2_up_wrap", 32'(bus.wrap),    32'h1);
        chk("t2_up_dir",  32'(bus.dir_up),  32'h1);
        apply(4'h8);
        chk("t2_dn_bin",  32'(bus.bin_out), 32'hF);
        chk("t2_dn_wrap", 32'(bus.wrap),    32'h1);
        chk("t2_dn_dir",  32'(bus.dir_up),  32'h0);

        // 3: walk to gray 0011, then a 2-bit jump and recovery
        apply(4'h0);
        apply(4'h1);
        apply(4'h3);
        chk("t3_pre_bin", 32'(bus.bin_out), 32'h2);
        apply(4'h5);
        chk("t3_serr",  32'(bus.step_err),  32'h1);
        chk("t3_ecnt",  32'(bus.err_cnt),   32'h1);
        chk("t3_hold",  32'(bus.bin_out),   32'h2);
        chk("t3_novld", 32'(bus.bin_valid), 32'h0);
        repeat (STAB - 1) tick();
        chk("t3_wait_vld", 32'(bus.bin_valid), 32'h0);
        chk("t3_wait_bin", 32'(bus.bin_out),   32'h2);
        tick();
        chk("t3_rec_vld",  32'(bus.bin_valid), 32'h1);
        chk("t3_rec_bin",  32'(bus.bin_out),   32'h6);
        chk("t3_rec_serr", 32'(bus.step_err),  32'h0);
        apply(4'h7);
        chk("t3_trk_bin", 32'(bus.bin_out),   32'h5);
        chk("t3_trk_vld", 32'(bus.bin_valid), 32'h1);
        chk("t3_trk_dir", 32'(bus.dir_up),    32'h0);

        // 4: err_cnt saturation, then clear coinciding with a step_err
        apply(4'h4);
        chk("t4_serr", 32'(bus.step_err), 32'h1);
        chk("t4_ecnt", 32'(bus.err_cnt),  32'h2);
        for (int i = 0; i < 300; i++) begin
            bus.gray_in = bus.gray_in ^ 4'h3;
            tick();
        end
        chk("t4_sat",      32'(bus.err_cnt),  32'hFF);
        chk("t4_sat_serr", 32'(bus.step_err), 32'h1);
        bus.gray_in = bus.gray_in ^ 4'h3;
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        chk("t4_clr_ecnt", 32'(bus.err_cnt),  32'h0);
        chk("t4_clr_serr", 32'(bus.step_err), 32'h1);

        // 5: reset while in ERR, release on gray 1100
        rst_n = 1'b0;
        #1;
        chk("t5_rst_bin",  32'(bus.bin_out),   32'h0);
        chk("t5_rst_vld",  32'(bus.bin_valid), 32'h0);
        chk("t5_rst_dir",  32'(bus.dir_up),    32'h0);
        chk("t5_rst_wrap", 32'(bus.wrap),      32'h0);
        chk("t5_rst_serr", 32'(bus.step_err),  32'h0);
        chk("t5_rst_ecnt", 32'(bus.err_cnt),   32'h0);
        bus.gray_in = 4'hC;
        tick();
        rst_n = 1'b1;
        repeat (LAT) tick();
        chk("t5_init_bin",  32'(bus.bin_out),   32'h8);
        chk("t5_init_vld",  32'(bus.bin_valid), 32'h0);
        chk("t5_init_serr", 32'(bus.step_err),  32'h0);
        chk("t5_init_wrap", 32'(bus.wrap),      32'h0);
        repeat (3) tick();
        chk("t5_post_serr", 32'(bus.step_err), 32'h0);
        chk("t5_post_bin",  32'(bus.bin_out),  32'h8);
        chk("t5_post_ecnt", 32'(bus.err_cnt),  32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
